// File: rtl/seq_detect_param.sv
// Event-sequence detector: rising edges on a/b become symbols 0/1 and are matched
// against a programmable pattern with longest-prefix-suffix fallback on every symbol.
module seq_detect_param #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8,
  parameter int STW     = $clog2(PAT_LEN + 1)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               a,
  input  logic               b,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic               overlap,
  input  logic               clr,
  output logic               out,
  output logic [STW-1:0]     state,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               err
);

  logic               a_d_reg, b_d_reg;
  logic [PAT_LEN-2:0] hist_reg, hist_next;
  logic [STW-1:0]     vcnt_reg, vcnt_next;
  logic [STW-1:0]     state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               out_reg, out_next;
  logic               err_reg, err_next;

  logic               rise_a, rise_b;
  logic [PAT_LEN-1:0] cat;
  logic [STW-1:0]     avail;
  logic [PAT_LEN:1]   hit;
  logic [STW-1:0]     fb;

  assign rise_a = a & ~a_d_reg;
  assign rise_b = b & ~b_d_reg;

  // cat[0] is the incoming symbol, cat[i] the symbol i positions older.
  assign cat   = {hist_reg, rise_b};
  assign avail = vcnt_reg + STW'(1);

  // hit[k]: the newest k symbols equal pattern[0..k-1], oldest first.
  for (genvar gi = 1; gi <= PAT_LEN; gi++) begin : g_hit
    logic eq;
    always_comb begin
      eq = (avail >= STW'(gi));
      for (int j = 0; j < gi; j++) begin
        if (cat[gi-1-j] != pattern[j]) eq = 1'b0;
      end
    end
    assign hit[gi] = eq;
  end

  always_comb begin
    fb = '0;
    for (int k = 1; k < PAT_LEN; k++) begin
      if (hit[k]) fb = STW'(k);
    end
  end

  always_comb begin
    out_next   = 1'b0;
    err_next   = 1'b0;
    state_next = state_reg;
    cnt_next   = cnt_reg;
    hist_next  = hist_reg;
    vcnt_next  = vcnt_reg;
    if (clr) begin
      state_next = '0;
      cnt_next   = '0;
      hist_next  = '0;
      vcnt_next  = '0;
    end else if (rise_a && rise_b) begin
      err_next   = 1'b1;
      state_next = '0;
      hist_next  = '0;
      vcnt_next  = '0;
    end else if (rise_a || rise_b) begin
      hist_next  = cat[PAT_LEN-2:0];
      vcnt_next  = (vcnt_reg == STW'(PAT_LEN - 1)) ? vcnt_reg : vcnt_reg + STW'(1);
      state_next = fb;
      if (hit[PAT_LEN]) begin
        out_next = 1'b1;
        if (cnt_reg != {CNT_W{1'b1}}) cnt_next = cnt_reg + CNT_W'(1);
        if (!overlap) begin
          state_next = '0;
          hist_next  = '0;
          vcnt_next  = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_d_reg   <= 1'b0;
      b_d_reg   <= 1'b0;
      hist_reg  <= '0;
      vcnt_reg  <= '0;
      state_reg <= '0;
      cnt_reg   <= '0;
      out_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      a_d_reg   <= a;
      b_d_reg   <= b;
      hist_reg  <= hist_next;
      vcnt_reg  <= vcnt_next;
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      out_reg   <= out_next;
      err_reg   <= err_next;
    end
  end

  assign out       = out_reg;
  assign err       = err_reg;
  assign state     = state_reg;
  assign match_cnt = cnt_reg;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: two instances (8-bit and 2-bit counters) share stimulus
// and are checked against a symbol-queue reference model plus hand-derived tables.
module tb_seq_detect_param;

  localparam int PL = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          a, b, clr, overlap;
  logic [PL-1:0] pattern;
  logic          out8, err8, out2, err2;
  logic [2:0]    state8, state2;
  logic [7:0]    cnt8;
  logic [1:0]    cnt2;

  seq_detect_param #(.PAT_LEN(PL), .CNT_W(8)) dut8 (
    .clk(clk), .resetn(resetn), .a(a), .b(b), .pattern(pattern), .overlap(overlap),
    .clr(clr), .out(out8), .state(state8), .match_cnt(cnt8), .err(err8));

  seq_detect_param #(.PAT_LEN(PL), .CNT_W(2)) dut2 (
    .clk(clk), .resetn(resetn), .a(a), .b(b), .pattern(pattern), .overlap(overlap),
    .clr(clr), .out(out2), .state(state2), .match_cnt(cnt2), .err(err2));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pulses8, pulses2;

  // Reference model: symbols since the last restart, newest at the back.
  int q[$];
  int m_state, m_c8, m_c2;
  bit m_out, m_err, pa, pb;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit tail_ok(input int k);
    if (q.size() < k) return 1'b0;
    for (int j = 0; j < k; j++)
      if (q[q.size() - k + j] != int'(pattern[j])) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_reset();
    q.delete();
    m_state = 0; m_c8 = 0; m_c2 = 0; m_out = 0; m_err = 0; pa = 0; pb = 0;
  endfunction

  function automatic void model_step();
    bit ra, rb, hit;
    int best;
    ra = a && !pa;
    rb = b && !pb;
    pa = a; pb = b;
    m_out = 0; m_err = 0;
    if (clr) begin
      q.delete(); m_state = 0; m_c8 = 0; m_c2 = 0;
    end else if (ra && rb) begin
      m_err = 1; q.delete(); m_state = 0;
    end else if (ra || rb) begin
      q.push_back(rb ? 1 : 0);
      if (q.size() > PL) void'(q.pop_front());
      hit = tail_ok(PL);
      best = 0;
      for (int k = 1; k < PL; k++) if (tail_ok(k)) best = k;
      m_state = best;
      if (hit) begin
        m_out = 1;
        if (m_c8 < 255) m_c8++;
        if (m_c2 < 3) m_c2++;
        if (!overlap) begin
          q.delete(); m_state = 0;
        end
      end
    end
  endfunction

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    if (out8) pulses8++;
    if (out2) pulses2++;
    chk("out8", out8, m_out);
    chk("err8", err8, m_err);
    chk("state8", state8, m_state);
    chk("cnt8", cnt8, m_c8);
    chk("out2", out2, m_out);
    chk("state2", state2, m_state);
    chk("cnt2", cnt2, m_c2);
  endtask

  // One symbol: line high for one cycle, then low for one cycle.
  int sym_state;
  task automatic sym(input int s);
    if (s != 0) b = 1'b1; else a = 1'b1;
    step();
    sym_state = state8;
    a = 1'b0; b = 1'b0;
    step();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
    pulses8 = 0; pulses2 = 0;
  endtask

  typedef struct {
    logic a, b, clr;
    int   st, o, e, c;
  } vec_t;
  vec_t tbl[25];

  initial begin
    int seen[4];
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1, 0, 0, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1, 0, 0, 0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1, 0, 0, 0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 2, 0, 0, 0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 2, 0, 0, 0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 2, 0, 0, 0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 3, 0, 0, 0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 3, 0, 0, 0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 3, 0, 0, 0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 2, 1, 0, 1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 2, 0, 0, 1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 2, 0, 0, 1};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 3, 0, 0, 1};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 3, 0, 0, 1};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 0, 0, 1, 1};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 1};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 1, 0, 0, 1};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1, 0, 0, 1};
    tbl[18] = '{1'b0, 1'b1, 1'b0, 2, 0, 0, 1};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 2, 0, 0, 1};
    tbl[20] = '{1'b1, 1'b0, 1'b0, 3, 0, 0, 1};
    tbl[21] = '{1'b0, 1'b0, 1'b0, 3, 0, 0, 1};
    tbl[22] = '{1'b0, 1'b1, 1'b1, 0, 0, 0, 0};
    tbl[23] = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 0};
    tbl[24] = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 0};

    resetn = 1'b0; a = 1'b0; b = 1'b0; clr = 1'b0; overlap = 1'b1; pattern = 4'b1010;
    pulses8 = 0; pulses2 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", state8, 0);
    chk("rst_out", out8, 0);
    chk("rst_err", err8, 0);
    chk("rst_cnt", cnt8, 0);
    resetn = 1'b1;

    // Basic match, simultaneous rise, clear priority (pattern ABAB, overlap on).
    do_clr();
    for (int i = 0; i < 25; i++) begin
      a = tbl[i].a; b = tbl[i].b; clr = tbl[i].clr;
      step();
      $display("row %0d: a=%0b b=%0b clr=%0b -> state=%0d out=%0b err=%0b cnt=%0d",
               i, a, b, clr, state8, out8, err8, cnt8);
      chk($sformatf("tbl%0d_state", i), state8, tbl[i].st);
      chk($sformatf("tbl%0d_out", i), out8, tbl[i].o);
      chk($sformatf("tbl%0d_err", i), err8, tbl[i].e);
      chk($sformatf("tbl%0d_cnt", i), cnt8, tbl[i].c);
    end
    a = 1'b0; b = 1'b0; clr = 1'b0;

    // Overlapping versus restart on ABABAB.
    overlap = 1'b1; do_clr();
    for (int i = 0; i < 6; i++) sym(i % 2);
    $display("ABABAB overlap=1: pulses=%0d cnt=%0d", pulses8, cnt8);
    chk("ovl_pulses", pulses8, 2);
    chk("ovl_cnt", cnt8, 2);
    overlap = 1'b0; do_clr();
    for (int i = 0; i < 6; i++) sym(i % 2);
    $display("ABABAB overlap=0: pulses=%0d cnt=%0d state=%0d", pulses8, cnt8, state8);
    chk("rst_pulses", pulses8, 1);
    chk("rst_cnt_val", cnt8, 1);
    chk("rst_final_state", state8, 2);

    // Fallback with the last A held high for six cycles.
    overlap = 1'b1; do_clr();
    sym(0); seen[0] = sym_state;
    sym(1); seen[1] = sym_state;
    sym(0); seen[2] = sym_state;
    a = 1'b1;
    step(); seen[3] = state8;
    repeat (5) step();
    a = 1'b0;
    step();
    $display("ABAA held: states %0d %0d %0d %0d final=%0d pulses=%0d",
             seen[0], seen[1], seen[2], seen[3], state8, pulses8);
    chk("fb_s1", seen[0], 1);
    chk("fb_s2", seen[1], 2);
    chk("fb_s3", seen[2], 3);
    chk("fb_s4", seen[3], 1);
    chk("fb_hold_state", state8, 1);
    chk("fb_pulses", pulses8, 0);

    // Asynchronous reset mid-sequence.
    do_clr();
    sym(0); sym(1); sym(0);
    chk("ar_pre_state", state8, 3);
    #3 resetn = 1'b0;
    #1;
    $display("async reset: state8=%0d state2=%0d", state8, state2);
    chk("ar_state8", state8, 0);
    chk("ar_state2", state2, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    model_reset();

    // Saturation of the 2-bit counter.
    overlap = 1'b0; do_clr();
    for (int i = 0; i < 20; i++) sym(i % 2);
    $display("saturation: pulses2=%0d cnt2=%0d cnt8=%0d", pulses2, cnt2, cnt8);
    chk("sat_pulses", pulses2, 5);
    chk("sat_cnt2", cnt2, 3);
    chk("sat_cnt8", cnt8, 5);

    // Randomized stimulus against the reference model.
    for (int blk = 0; blk < 6; blk++) begin
      pattern = PL'($urandom);
      overlap = 1'($urandom_range(0, 1));
      do_clr();
      for (int i = 0; i < 400; i++) begin
        a   = ($urandom_range(0, 2) == 0);
        b   = ($urandom_range(0, 2) == 0);
        clr = ($urandom_range(0, 99) == 0);
        step();
      end
      clr = 1'b0; a = 1'b0; b = 1'b0;
      $display("random block %0d: pattern=%b overlap=%0b pulses=%0d cnt8=%0d cnt2=%0d",
               blk, pattern, overlap, pulses8, cnt8, cnt2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
